// File: rtl/dsp_mac_frame_if.sv
// rtl/dsp_mac_frame_if.sv - sample-in / frame-result handshake bundle for dsp_mac_frame
// master = sample source and result consumer, slave = the MAC slice.
interface dsp_mac_frame_if #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18,
  parameter int C_WIDTH = 48,
  parameter int P_WIDTH = 48,
  parameter int ACC_LEN = 16
);
  localparam int CNT_W = $clog2(ACC_LEN) + 1;

  logic                      IN_VALID;
  logic                      IN_READY;
  logic signed [A_WIDTH-1:0] A;
  logic signed [B_WIDTH-1:0] B;
  logic signed [B_WIDTH-1:0] D;
  logic signed [C_WIDTH-1:0] C;
  logic [4:0]                OPMODE;
  logic signed [P_WIDTH-1:0] P;
  logic                      P_VALID;
  logic                      P_READY;
  logic                      OVERFLOW;
  logic                      PATTERN_DETECT;
  logic [CNT_W-1:0]          SAMPLE_CNT;

  modport master (
    output IN_VALID, A, B, D, C, OPMODE, P_READY,
    input  IN_READY, P, P_VALID, OVERFLOW, PATTERN_DETECT, SAMPLE_CNT
  );

  modport slave (
    input  IN_VALID, A, B, D, C, OPMODE, P_READY,
    output IN_READY, P, P_VALID, OVERFLOW, PATTERN_DETECT, SAMPLE_CNT
  );
endinterface

// File: rtl/dsp_mac_frame.sv
// rtl/dsp_mac_frame.sv - pipelined pre-add/multiply/frame-accumulate slice with valid/ready flow
// Stages: input reg -> pre-adder reg -> multiplier reg -> accumulator/result reg.
module dsp_mac_frame #(
  parameter int                 A_WIDTH  = 18,
  parameter int                 B_WIDTH  = 18,
  parameter int                 C_WIDTH  = 48,
  parameter int                 P_WIDTH  = 48,
  parameter int                 ACC_LEN  = 16,
  parameter int                 SATURATE = 1,
  parameter logic [P_WIDTH-1:0] PATTERN  = '0,
  parameter logic [P_WIDTH-1:0] MASK     = '0
) (
  input logic             CLK,
  input logic             RSTN,
  dsp_mac_frame_if.slave  io
);
  localparam int CNT_W = $clog2(ACC_LEN) + 1;
  localparam int MW    = A_WIDTH + B_WIDTH + 1;
  localparam int SW    = P_WIDTH + 2;

  localparam logic signed [SW-1:0]      SUM_MAX  = {3'b000, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0]      SUM_MIN  = {3'b111, {(P_WIDTH-1){1'b0}}};
  localparam logic signed [P_WIDTH-1:0] P_MAX    = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [P_WIDTH-1:0] P_MIN    = {1'b1, {(P_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]          LAST_CNT = CNT_W'(ACC_LEN - 1);

  // stage 1: raw sample
  logic signed [A_WIDTH-1:0] a1_q, a1_d;
  logic signed [B_WIDTH-1:0] b1_q, b1_d, d1_q, d1_d;
  logic signed [C_WIDTH-1:0] c1_q, c1_d;
  logic [4:0]                op1_q, op1_d;
  logic                      v1_q, v1_d;
  // stage 2: pre-adder result
  logic signed [A_WIDTH-1:0] a2_q, a2_d;
  logic signed [B_WIDTH:0]   pre2_q, pre2_d;
  logic signed [C_WIDTH-1:0] c2_q, c2_d;
  logic [4:0]                op2_q, op2_d;
  logic                      v2_q, v2_d;
  // stage 3: product
  logic signed [MW-1:0]      m3_q, m3_d;
  logic signed [C_WIDTH-1:0] c3_q, c3_d;
  logic [4:0]                op3_q, op3_d;
  logic                      v3_q, v3_d;
  // stage 4: frame accumulator and result
  logic signed [P_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      sticky_q, sticky_d;
  logic signed [P_WIDTH-1:0] p_q, p_d;
  logic                      p_ovf_q, p_ovf_d;
  logic                      p_valid_q, p_valid_d;

  logic                      stall;
  logic signed [B_WIDTH:0]   d_ext, b_ext, pre;
  logic signed [MW-1:0]      a_ext, pre_ext, prod;
  logic signed [SW-1:0]      m_ext, term, bias, base, sum;
  logic                      sum_ovf;
  logic signed [P_WIDTH-1:0] sum_res;
  logic                      frame_end;

  assign stall = p_valid_q & ~io.P_READY;

  always_comb begin
    a1_d      = a1_q;
    b1_d      = b1_q;
    d1_d      = d1_q;
    c1_d      = c1_q;
    op1_d     = op1_q;
    v1_d      = v1_q;
    a2_d      = a2_q;
    pre2_d    = pre2_q;
    c2_d      = c2_q;
    op2_d     = op2_q;
    v2_d      = v2_q;
    m3_d      = m3_q;
    c3_d      = c3_q;
    op3_d     = op3_q;
    v3_d      = v3_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    p_d       = p_q;
    p_ovf_d   = p_ovf_q;
    p_valid_d = p_valid_q;

    d_ext = {d1_q[B_WIDTH-1], d1_q};
    b_ext = {b1_q[B_WIDTH-1], b1_q};
    if (op1_q[0]) begin
      pre = op1_q[1] ? (d_ext - b_ext) : (d_ext + b_ext);
    end else begin
      pre = b_ext;
    end

    a_ext   = {{(B_WIDTH+1){a2_q[A_WIDTH-1]}}, a2_q};
    pre_ext = {{A_WIDTH{pre2_q[B_WIDTH]}}, pre2_q};
    prod    = a_ext * pre_ext;

    // Two guard bits keep base+term+bias exact so range checks see the true sum.
    m_ext = {{(SW-MW){m3_q[MW-1]}}, m3_q};
    term  = op3_q[3] ? -m_ext : m_ext;
    bias  = op3_q[2] ? {{(SW-C_WIDTH){c3_q[C_WIDTH-1]}}, c3_q} : '0;
    base  = (cnt_q == '0) ? '0 : {{2{acc_q[P_WIDTH-1]}}, acc_q};
    sum   = base + term + bias;

    sum_ovf = (sum > SUM_MAX) || (sum < SUM_MIN);
    if (sum_ovf && (SATURATE != 0)) begin
      sum_res = sum[SW-1] ? P_MIN : P_MAX;
    end else begin
      sum_res = sum[P_WIDTH-1:0];
    end

    frame_end = v3_q & ((cnt_q == LAST_CNT) | op3_q[4]);

    if (!stall) begin
      v1_d   = io.IN_VALID;
      a1_d   = io.A;
      b1_d   = io.B;
      d1_d   = io.D;
      c1_d   = io.C;
      op1_d  = io.OPMODE;

      v2_d   = v1_q;
      a2_d   = a1_q;
      pre2_d = pre;
      c2_d   = c1_q;
      op2_d  = op1_q;

      v3_d   = v2_q;
      m3_d   = prod;
      c3_d   = c2_q;
      op3_d  = op2_q;

      // Not stalled means any held result is being consumed this edge.
      p_valid_d = frame_end;
      if (frame_end) begin
        p_d      = sum_res;
        p_ovf_d  = sticky_q | sum_ovf;
        acc_d    = '0;
        cnt_d    = '0;
        sticky_d = 1'b0;
      end else if (v3_q) begin
        acc_d    = sum_res;
        cnt_d    = cnt_q + CNT_W'(1);
        sticky_d = sticky_q | sum_ovf;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      a1_q      <= '0;
      b1_q      <= '0;
      d1_q      <= '0;
      c1_q      <= '0;
      op1_q     <= '0;
      v1_q      <= 1'b0;
      a2_q      <= '0;
      pre2_q    <= '0;
      c2_q      <= '0;
      op2_q     <= '0;
      v2_q      <= 1'b0;
      m3_q      <= '0;
      c3_q      <= '0;
      op3_q     <= '0;
      v3_q      <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      p_q       <= '0;
      p_ovf_q   <= 1'b0;
      p_valid_q <= 1'b0;
    end else begin
      a1_q      <= a1_d;
      b1_q      <= b1_d;
      d1_q      <= d1_d;
      c1_q      <= c1_d;
      op1_q     <= op1_d;
      v1_q      <= v1_d;
      a2_q      <= a2_d;
      pre2_q    <= pre2_d;
      c2_q      <= c2_d;
      op2_q     <= op2_d;
      v2_q      <= v2_d;
      m3_q      <= m3_d;
      c3_q      <= c3_d;
      op3_q     <= op3_d;
      v3_q      <= v3_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      p_q       <= p_d;
      p_ovf_q   <= p_ovf_d;
      p_valid_q <= p_valid_d;
    end
  end

  assign io.IN_READY       = RSTN & ~stall;
  assign io.P              = p_q;
  assign io.P_VALID        = p_valid_q;
  assign io.OVERFLOW       = p_ovf_q;
  assign io.SAMPLE_CNT     = cnt_q;
  assign io.PATTERN_DETECT = ((p_q ^ PATTERN) & ~MASK) == '0;
endmodule
